// File: rtl/fir_output_stage.sv
// fir_output_stage: back end of the 41-tap lowpass FIR.
// It re-times the input valid strobe to the FIR output, drops the start-up
// partial sums, decimates by DECIM and queues the kept samples in a FIFO
// with a valid/ready interface to the consumer.
//
// Optional feature: define FIR_OUT_PEAK_EN to add a peak-magnitude tracker
// over the written samples (adds peak_clr input and peak_abs output).
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   reset       synchronous, active-high
//   in_valid    valid strobe presented to the FIR together with x
//   fir_y       FIR output sample, two's complement
//   out_data    FIFO head sample
//   out_valid   out_data is valid
//   out_ready   consumer accepts when out_valid & out_ready
//   fifo_level  current FIFO occupancy
//   overflow    sticky: a kept sample was dropped because the FIFO was full
//   peak_clr    (FIR_OUT_PEAK_EN) clear peak_abs
//   peak_abs    (FIR_OUT_PEAK_EN) largest |sample| written since reset/clear
module fir_output_stage #(
  parameter int unsigned DATA_W      = 17,
  parameter int unsigned FIR_LATENCY = 1,
  parameter int unsigned WARMUP      = 40,
  parameter int unsigned DECIM       = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             fir_y,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef FIR_OUT_PEAK_EN
  ,
  input  logic                          peak_clr,
  output logic [DATA_W-1:0]             peak_abs
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [FIR_LATENCY-1:0] vld_sr;
  logic                   y_valid;
  logic [WU_W-1:0]        wu_cnt;
  logic                   warm_done;
  logic [DEC_W-1:0]       dec_cnt;
  logic                   keep;

  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_nxt;
  logic                   pop;
  logic                   full;
  logic                   push;
  logic                   drop;
  logic [LVL_W-1:0]       remain;
  logic [LVL_W-1:0]       level_nxt;

  // Valid delay chain matching the FIR pipeline latency
  if (FIR_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk_100MHz) begin
      if (reset) vld_sr <= '0;
      else       vld_sr <= in_valid;
    end
  end else begin : g_latn
    always_ff @(posedge clk_100MHz) begin
      if (reset) vld_sr <= '0;
      else       vld_sr <= {vld_sr[FIR_LATENCY-2:0], in_valid};
    end
  end

  assign y_valid   = vld_sr[FIR_LATENCY-1];
  assign warm_done = (wu_cnt == WU_W'(WARMUP));
  assign keep      = y_valid & warm_done & (dec_cnt == '0);

  // FIFO control; a full FIFO still accepts a push when the head leaves in the same cycle
  assign pop        = out_valid & out_ready;
  assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push       = keep & (~full | pop);
  assign drop       = keep & full & ~pop;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign remain     = fifo_level - LVL_W'(pop);
  assign level_nxt  = remain + LVL_W'(push);

  // Warm-up discard and decimation counters
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wu_cnt  <= '0;
      dec_cnt <= '0;
    end else if (y_valid) begin
      if (!warm_done)                       wu_cnt  <= wu_cnt + WU_W'(1);
      else if (dec_cnt == DEC_W'(DECIM - 1)) dec_cnt <= '0;
      else                                  dec_cnt <= dec_cnt + DEC_W'(1);
    end
  end

  // Sample storage (no reset needed, contents are qualified by the pointers)
  always_ff @(posedge clk_100MHz) begin
    if (push) mem[wr_ptr] <= fir_y;
  end

  // Pointers, level and the registered head; a push into an otherwise empty
  // FIFO loads the head register straight from fir_y
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      out_valid  <= (level_nxt != '0);
      if (level_nxt != '0) begin
        out_data <= (remain == '0) ? fir_y : mem[rd_ptr_nxt];
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef FIR_OUT_PEAK_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] abs_y;

  // Magnitude of the incoming sample, most negative value saturated
  always_comb begin
    abs_y = fir_y;
    if (fir_y == MOST_NEG)    abs_y = MAX_POS;
    else if (fir_y[DATA_W-1]) abs_y = -fir_y;
  end

  // Peak tracker over written samples; clear wins over an update
  always_ff @(posedge clk_100MHz) begin
    if (reset)                         peak_abs <= '0;
    else if (peak_clr)                 peak_abs <= '0;
    else if (push && abs_y > peak_abs) peak_abs <= abs_y;
  end
`endif

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from an index-based behavioural model.
module tb_fir_output_stage;

  localparam int DATA_W      = 17;
  localparam int FIR_LATENCY = 1;
  localparam int WARMUP      = 40;
  localparam int DECIM       = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int MAX_MAG     = (1 << (DATA_W - 1)) - 1;

  logic              clk_100MHz = 1'b0;
  logic              reset      = 1'b1;
  logic              in_valid   = 1'b0;
  logic [DATA_W-1:0] fir_y      = '0;
  logic              out_ready  = 1'b0;
  logic              peak_clr   = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
`ifdef FIR_OUT_PEAK_EN
  logic [DATA_W-1:0] peak_abs;
`endif

  fir_output_stage #(
    .DATA_W(DATA_W), .FIR_LATENCY(FIR_LATENCY), .WARMUP(WARMUP),
    .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .in_valid  (in_valid),
    .fir_y     (fir_y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow)
`ifdef FIR_OUT_PEAK_EN
    ,
    .peak_clr  (peak_clr),
    .peak_abs  (peak_abs)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];     // samples expected on the output, in order
  logic [DATA_W-1:0] popped[$];    // DUT samples accepted by the consumer
  logic [DATA_W-1:0] val_list[$];  // values to place on kept samples (mode 2)
  int                stamps[$];    // edge numbers at which in_valid was captured
  int                edge_no  = 0;
  int                m_n      = 0; // aligned samples since reset
  int                m_occ    = 0;
  bit                m_ovf    = 1'b0;
  int                m_peak   = 0;
  bit                checking = 1'b0;
  int                fy_mode  = 1; // 0 random, 1 sample index, 2 value list

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag(input logic [DATA_W-1:0] y);
    int v;
    v = int'($signed(y));
    if (v < 0) v = -v;
    if (v > MAX_MAG) v = MAX_MAG;
    return v;
  endfunction

  // A sample presented with x at edge k appears as y at edge k+FIR_LATENCY
  function automatic bit aligned_next();
    return (stamps.size() > 0) && (stamps[0] == edge_no + 1 - FIR_LATENCY);
  endfunction

  function automatic bit keep_next();
    return aligned_next() && (m_n >= WARMUP) && (((m_n - WARMUP) % DECIM) == 0);
  endfunction

  // Apply what the DUT should have done at the edge that just occurred
  task automatic model_update(input bit rst, input bit iv, input bit rdy,
                              input bit pclr, input logic [DATA_W-1:0] y);
    bit al, kept, wrote, pop;
    edge_no++;
    if (rst) begin
      exp_q.delete();
      stamps.delete();
      m_occ = 0; m_ovf = 1'b0; m_n = 0; m_peak = 0;
      checking = 1'b1;
      return;
    end
    al = (stamps.size() > 0) && (stamps[0] == edge_no - FIR_LATENCY);
    if (al) void'(stamps.pop_front());
    pop   = (m_occ > 0) && rdy;
    kept  = 1'b0;
    wrote = 1'b0;
    if (al) begin
      kept = (m_n >= WARMUP) && (((m_n - WARMUP) % DECIM) == 0);
      m_n++;
    end
    if (kept) begin
      if (m_occ < FIFO_DEPTH || pop) begin
        exp_q.push_back(y);
        m_occ++;
        wrote = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) m_occ--;
    if (iv) stamps.push_back(edge_no);
    if (pclr) m_peak = 0;
    else if (wrote && mag(y) > m_peak) m_peak = mag(y);
  endtask

  // One clock of stimulus; returns #1 after the edge with the model updated
  task automatic step(input bit rst, input bit iv, input bit rdy, input bit pclr);
    reset     = rst;
    in_valid  = iv;
    out_ready = rdy;
    peak_clr  = pclr;
    case (fy_mode)
      1:       fir_y = aligned_next() ? DATA_W'(m_n) : DATA_W'($urandom);
      2:       fir_y = (keep_next() && val_list.size() > 0) ? val_list.pop_front()
                                                            : DATA_W'($urandom);
      default: fir_y = DATA_W'($urandom);
    endcase
    @(posedge clk_100MHz);
    #1;
    model_update(rst, iv, rdy, pclr, fir_y);
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk_100MHz) begin
    if (checking) begin
      chk("out_valid", 32'(out_valid), 32'(m_occ > 0));
      chk("fifo_level", 32'(fifo_level), 32'(m_occ));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FIR_OUT_PEAK_EN
      chk("peak_abs", 32'(peak_abs), 32'(m_peak));
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data: got %0h with no sample expected at %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped.push_back(out_data);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    int thr;
    logic [DATA_W-1:0] pushed_v;
    logic [DATA_W-1:0] pk_exp [3];
    pk_exp[0] = 17'h00123;
    pk_exp[1] = 17'h00123;
    pk_exp[2] = 17'h0FFFF;

    // Continuous valid, index samples: 40, 44, 48, 52
    fy_mode = 1;
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    popped.delete();
    repeat (70) step(0, 1, 1, 0);
    chk("p1_count_ge4", 32'(popped.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < popped.size(); k++)
      chk("p1_seq", 32'(popped[k]), 32'(40 + 4 * k));

    // Alternating valid: gaps must not advance the counters
    step(1, 0, 1, 0);
    popped.delete();
    for (int i = 0; i < 140; i++) step(0, (i % 2) == 0, 1, 0);
    chk("p2_count_ge3", 32'(popped.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < popped.size(); k++)
      chk("p2_seq", 32'(popped[k]), 32'(40 + 4 * k));

    // Stalled consumer: fill, drop, sticky overflow, ordered drain
    step(1, 0, 0, 0);
    popped.delete();
    repeat (84) step(0, 1, 0, 0);
    chk("p3_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
    chk("p3_overflow", 32'(overflow), 32'd1);
    repeat (20) step(0, 0, 1, 0);
    chk("p3_drained", 32'(popped.size()), 32'(FIFO_DEPTH));
    for (int k = 0; k < FIFO_DEPTH && k < popped.size(); k++)
      chk("p3_order", 32'(popped[k]), 32'(40 + 4 * k));
    chk("p3_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with push and pop in the same cycle
    step(1, 0, 0, 0);
    guard = 0;
    while (m_occ < FIFO_DEPTH && guard < 200) begin
      step(0, 1, 0, 0);
      guard++;
    end
    chk("p4_fill", 32'(fifo_level), 32'(FIFO_DEPTH));
    guard = 0;
    while (!keep_next() && guard < 20) begin
      step(0, 1, 0, 0);
      guard++;
    end
    pushed_v = DATA_W'(m_n);
    popped.delete();
    step(0, 1, 1, 0);
    chk("p4_level_same", 32'(fifo_level), 32'(FIFO_DEPTH));
    chk("p4_no_overflow", 32'(overflow), 32'd0);
    repeat (20) step(0, 0, 1, 0);
    chk("p4_count", 32'(popped.size()), 32'(FIFO_DEPTH + 1));
    if (popped.size() >= 9) chk("p4_pushed_8th", 32'(popped[8]), 32'(pushed_v));

    // Reset mid-operation with five queued samples
    step(1, 0, 0, 0);
    guard = 0;
    while (m_occ < 5 && guard < 200) begin
      step(0, 1, 0, 0);
      guard++;
    end
    chk("p5_level5", 32'(fifo_level), 32'd5);
    step(1, 1, 0, 0);
    chk("p5_out_valid", 32'(out_valid), 32'd0);
    chk("p5_level0", 32'(fifo_level), 32'd0);
    chk("p5_overflow0", 32'(overflow), 32'd0);
    popped.delete();
    repeat (50) step(0, 1, 1, 0);
    chk("p5_any", 32'(popped.size() >= 1), 32'd1);
    if (popped.size() >= 1) chk("p5_first_after_warmup", 32'(popped[0]), 32'd40);

`ifdef FIR_OUT_PEAK_EN
    // Peak tracking with a saturating most-negative sample, then clear
    step(1, 0, 1, 0);
    fy_mode = 2;
    val_list = '{17'h00123, 17'h1FF00, 17'h10000};
    guard = 0;
    while (val_list.size() > 0 && guard < 100) begin
      int before;
      before = val_list.size();
      step(0, 1, 1, 0);
      if (val_list.size() < before) chk("p6_peak", 32'(peak_abs), 32'(pk_exp[2 - val_list.size()]));
      guard++;
    end
    chk("p6_list_used", 32'(val_list.size()), 32'd0);
    step(0, 0, 1, 1);
    chk("p6_peak_clr", 32'(peak_abs), 32'd0);
`endif

    // Randomized traffic with varying backpressure and occasional resets
    fy_mode = 0;
    for (int blk = 0; blk < 6; blk++) begin
      case (blk % 3)
        0:       thr = 10;
        1:       thr = 50;
        default: thr = 90;
      endcase
      repeat (500)
        step($urandom_range(0, 599) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 99) < thr, $urandom_range(0, 31) == 0);
    end
    repeat (30) step(0, 0, 1, 0);
    chk("final_drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
Downstream stage of the 41-tap lowpass FIR. It consumes the FIR's 17-bit output and the same valid strobe that feeds the FIR input.
- Realigns valid to the FIR pipeline latency.
- Discards the start-up partial sums.
- Decimates by a fixed ratio.
- Buffers kept samples in a small FIFO with a valid/ready handshake to the consumer (DAC/UART/DMA packer).

Parameters:
DATA_W, 17, sample width (matches FIR y)
FIR_LATENCY, 1, clocks from FIR input x to corresponding y (delay applied to in_valid); legal range 1..8
WARMUP, 40, aligned valid samples discarded after reset (taps-1 partial sums)
DECIM, 4, decimation ratio; 1 = pass every sample
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2

Ports:
clk_100MHz  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  valid strobe presented to FIR alongside x
fir_y  in  DATA_W  FIR output, two's complement
out_data  out  DATA_W  FIFO head sample
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid & out_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a kept sample was dropped

Behaviour:
- Alignment:
  - in_valid is passed through a FIR_LATENCY-deep register chain; its output is y_valid.
  - fir_y is sampled only in cycles where y_valid=1. fir_y is ignored otherwise.
- Warm-up:
  - A counter (0..WARMUP) increments on each y_valid and saturates at WARMUP.
  - Samples are discarded while the count is < WARMUP.
  - WARMUP=0 disables discard.
- Decimation:
  - dec_cnt (0..DECIM-1) advances only on post-warm-up y_valid cycles and wraps DECIM-1 -> 0.
  - A sample is kept when dec_cnt==0, so the first post-warm-up sample is kept.
  - Cycles with in_valid=0 do not advance any counter.
- FIFO:
  - A kept sample is written on the same clock edge on which it is sampled. out_valid asserts on the following cycle when the FIFO was empty; there is no bypass path.
  - Pop occurs when out_valid & out_ready.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
  - Full with push and no pop: the sample is dropped, overflow<=1, and level stays at FIFO_DEPTH.
  - Full with push and pop in the same cycle: both succeed, level is unchanged, no overflow.
  - Empty with pop: impossible (out_valid=0).
  - Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- overflow clears only on reset.
- Reset:
  - Valid delay chain, warm-up counter, dec_cnt, pointers, fifo_level, overflow and out_valid are all set to 0; out_data is set to 0.
  - Reset asserted mid-operation flushes the FIFO and restarts warm-up. Samples in flight are lost.
- No arithmetic on sample data in the base block; the sample width is preserved.

Optional Feature:
FIR_OUT_PEAK_EN
- Defined:
  - Adds output peak_abs [DATA_W-1:0] (reset 0) and input peak_clr [1].
  - On each FIFO write (kept sample actually written), peak_abs <= max(peak_abs, |sample|).
  - |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
  - peak_clr=1 sets peak_abs to 0 and takes priority over an update in the same cycle.
- Not defined: neither port exists and no peak logic is synthesized.

Test Plan:
1. Defaults; reset, then in_valid=1 continuous, fir_y=sample index n (aligned), out_ready=1 -> first out_data=40, then 44, 48, 52; out_valid high 1 cycle in 4; overflow=0.
2. in_valid pattern 1,0,1,0...; fir_y aligned index counting valid samples only -> same output sequence 40, 44, 48; gap cycles do not advance the decimation or warm-up counters.
3. out_ready=0, DECIM=1, 9 post-warm-up samples 100..108 -> fifo_level=8, 108 dropped, overflow=1; then out_ready=1 -> 100..107 out in order, overflow stays 1.
4. FIFO full (level 8), out_ready=1 in the same cycle as a kept push -> level stays 8, overflow stays 0, pushed value emerges 8th.
5. Reset pulsed 1 cycle with level=5 -> next cycle out_valid=0, fifo_level=0, overflow=0; 40 further aligned samples discarded before the next write.
6. FIR_OUT_PEAK_EN defined; kept samples 17'h00123, 17'h1FF00 (-256), 17'h10000 -> peak_abs 17'h00123, then 17'h00123 (291 > 256), then 17'h0FFFF; peak_clr=1 -> 0.
